// File: rtl/distance_display_pkg.sv
// ---------------------------------------------------------------------------
// distance_pkg : shared types and constants for the distance display slice.
//   seg7_t       7-bit active-low segment vector {g,f,e,d,c,b,a}, 0 = lit
//   SEG_*        fixed glyphs (blank, dash, error 'E')
//   slot_e       scan slot encodings, slot 0 = leftmost position
//   digits_t     one frame's worth of BCD digits {km, hundreds, tens}
//   an_for_slot  active-low one-cold digit enable for a slot
// ---------------------------------------------------------------------------
package distance_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b0111111;
  localparam seg7_t SEG_E     = 7'b0000110;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    SLOT_KM   = 2'd0,  // km digit
    SLOT_DASH = 2'd1,  // separator
    SLOT_HM   = 2'd2,  // hundreds of metres
    SLOT_TM   = 2'd3   // tens of metres
  } slot_e;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
  } digits_t;

  function automatic logic [3:0] an_for_slot(slot_e s);
    an_for_slot = ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/distance_display_if.sv
// ---------------------------------------------------------------------------
// distance_display_if : digit inputs and display pin outputs of the display.
//   distance1/2/3  BCD digits from the distance counter (km, 100 m, 10 m)
//   seg            active-low segments {g,f,e,d,c,b,a}
//   an             active-low digit enables, an[0] = leftmost
//   frame_tick     one-clock pulse when a new frame snapshot is taken
// master = digit source / pin observer, slave = the display block.
// ---------------------------------------------------------------------------
interface distance_display_if;
  import distance_pkg::*;

  logic [3:0] distance1;
  logic [3:0] distance2;
  logic [3:0] distance3;
  seg7_t      seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output distance1, distance2, distance3,
    input  seg, an, frame_tick
  );

  modport slave (
    input  distance1, distance2, distance3,
    output seg, an, frame_tick
  );

endinterface

// File: rtl/distance_display_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7 : combinational BCD to active-low 7-segment decoder.
//   bcd_i  4-bit digit; 0-9 standard glyphs, 10-15 show 'E'
//   seg_o  segments {g,f,e,d,c,b,a}, 0 = lit
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import distance_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg7_t      seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/distance_display.sv
// ---------------------------------------------------------------------------
// distance_display : 4-position multiplexed 7-segment driver showing "K-MM".
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   dsp      distance_display_if.slave (digits in, seg/an/frame_tick out)
// Parameter REFRESH_DIV : clocks per digit slot (>= 2).
// Build option DISTANCE_DISPLAY_LZB_EN : blank a leading km zero in slot 0
// while still enabling an[0], so per-digit duty does not change.
//
// The digits are captured once per frame (on the slot-3 -> slot-0 tick), so
// a frame is always drawn from one consistent set of digits. an and seg are
// registered together from the same slot index, one clock behind it, which
// guarantees a new enable is never paired with the previous slot's pattern.
// ---------------------------------------------------------------------------
module distance_display
  import distance_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset_n,
  distance_display_if.slave dsp
);

`ifdef DISTANCE_DISPLAY_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pre_q,  pre_d;
  slot_e         idx_q,  idx_d;
  digits_t       snap_q, snap_d;
  logic          ft_q,   ft_d;
  seg7_t         seg_q,  seg_d;
  logic [3:0]    an_q,   an_d;

  logic          tick;
  logic [3:0]    dec_in;
  seg7_t         dec_seg;

  assign tick = (pre_q == PRE_LAST);

  // Scan sequencing: prescaler, slot index and the per-frame snapshot.
  always_comb begin
    pre_d  = tick ? '0 : pre_q + PW'(1);
    idx_d  = idx_q;
    snap_d = snap_q;
    ft_d   = 1'b0;
    if (tick) begin
      idx_d = slot_e'(idx_q + 2'd1);
      if (idx_q == SLOT_TM) begin
        snap_d = '{d1: dsp.distance1, d2: dsp.distance2, d3: dsp.distance3};
        ft_d   = 1'b1;
      end
    end
  end

  // Single shared decoder; the dash slot's input is don't-care.
  always_comb begin
    dec_in = 4'd0;
    case (idx_q)
      SLOT_KM: dec_in = snap_q.d1;
      SLOT_HM: dec_in = snap_q.d2;
      SLOT_TM: dec_in = snap_q.d3;
      default: dec_in = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (dec_in),
    .seg_o (dec_seg)
  );

  // Pin patterns for the current slot; both land on the same edge.
  always_comb begin
    an_d  = an_for_slot(idx_q);
    seg_d = dec_seg;
    if (idx_q == SLOT_DASH)
      seg_d = SEG_DASH;
    else if (LZB_EN && idx_q == SLOT_KM && snap_q.d1 == 4'd0)
      seg_d = SEG_BLANK;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      idx_q  <= SLOT_KM;
      snap_q <= '0;
      ft_q   <= 1'b0;
      seg_q  <= SEG_BLANK;
      an_q   <= AN_OFF;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      ft_q   <= ft_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign dsp.seg        = seg_q;
  assign dsp.an         = an_q;
  assign dsp.frame_tick = ft_q;

endmodule

// File: tb/tb_distance_display.sv
// ---------------------------------------------------------------------------
// tb_distance_display : self-checking bench for distance_display with
// REFRESH_DIV=4. The reference model counts clock edges since reset release
// and derives slot, snapshot edges and frame_tick from that count directly.
// Build with or without DISTANCE_DISPLAY_LZB_EN to match the RTL build.
// ---------------------------------------------------------------------------
module tb_distance_display;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  // Reference glyphs, indexed by digit value.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
    7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110
  };

  logic clock;
  logic reset_n;

  distance_display_if dif ();

  distance_display #(.REFRESH_DIV(DIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dsp     (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          k      = 0;      // edges since reset release
  logic [11:0] cur_d  = '0;     // digits currently driven {d1,d2,d3}
  logic [11:0] snap_m = '0;     // model snapshot

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s k=%0d act=%0h exp=%0h", tag, k, act, exp);
  endtask

  function automatic logic [6:0] model_seg(input int slot, input logic [11:0] s);
    logic [3:0] d1;
    d1 = s[11:8];
    case (slot)
      0: begin
`ifdef DISTANCE_DISPLAY_LZB_EN
        if (d1 == 4'd0) return 7'b1111111;
`endif
        return GLYPH[d1];
      end
      1:       return 7'b0111111;
      2:       return GLYPH[s[7:4]];
      default: return GLYPH[s[3:0]];
    endcase
  endfunction

  task automatic set_d(input logic [11:0] v);
    cur_d = v;
    dif.distance1 = v[11:8];
    dif.distance2 = v[7:4];
    dif.distance3 = v[3:0];
  endtask

  // One clock edge, then compare the pins against the model.
  task automatic step();
    int          slot;
    logic [11:0] shown;
    logic [3:0]  an_exp;
    @(posedge clock);
    k++;
    shown = snap_m;
    if (k % FRAME == 0) snap_m = cur_d;
    slot   = ((k - 1) / DIV) % 4;
    an_exp = 4'b1111;
    an_exp[slot] = 1'b0;
    #1;
    chk("an",  dif.an,  an_exp);
    chk("seg", dif.seg, model_seg(slot, shown));
    chk("ft",  dif.frame_tick, (k % FRAME == 0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_an"},  dif.an,  4'b1111);
    chk({tag, "_seg"}, dif.seg, 7'b1111111);
    chk({tag, "_ft"},  dif.frame_tick, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    set_d(12'h000);

    // 1. reset held, then released
    repeat (3) begin
      @(posedge clock); #1;
      chk_reset_state("rst");
    end
    reset_n = 1'b1;
    k = 0; snap_m = '0;

    // 2. steady 3,4,7 for several frames
    set_d(12'h347);
    repeat (3 * FRAME) step();

    // 3. distance3 7->8 during slot 1 of a frame
    while ((k / DIV) % 4 != 1) step();
    step();
    set_d(12'h348);
    repeat (2 * FRAME) step();

    // 4. non-BCD hundreds digit
    set_d(12'h5C2);
    repeat (2 * FRAME) step();

    // 5. one-clock reset pulse during slot 2
    while ((k / DIV) % 4 != 2) step();
    step();
    reset_n = 1'b0;
    #1;
    chk_reset_state("arst");
    @(posedge clock); #1;
    chk_reset_state("arst_hold");
    #1;
    reset_n = 1'b1;
    k = 0; snap_m = '0;
    repeat (2 * FRAME) step();

    // 6. leading zero km digit
    set_d(12'h019);
    repeat (2 * FRAME) step();

    // random digits changing at random points in the frame
    repeat (400) begin
      if ($urandom_range(3) == 0) set_d(12'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog: the sequence above is bounded, this only guards a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog k=%0d act=timeout exp=finish", k);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

endmodule
